// File: rtl/abft_pkg.sv
// abft_pkg: shared definitions for the ABFT checksum-check path.
//   - default tile geometry and checksum width
//   - FSM state enum plus fixed 3-bit state constants
//   - result record handed to the fault-handling logic
package abft_pkg;

  localparam int ARRAY_SIZE = 4;
  localparam int ADDR_W     = 2;
  localparam int Z_BITS     = 28;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    SEARCH   = 3'd2,
    ZCHK     = 3'd3,
    REPORT   = 3'd4
  } state_e;

  // Fixed encodings so the state register can stay a plain logic vector.
  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_CLASSIFY = CLASSIFY;
  localparam logic [2:0] ST_SEARCH   = SEARCH;
  localparam logic [2:0] ST_ZCHK     = ZCHK;
  localparam logic [2:0] ST_REPORT   = REPORT;

  typedef struct packed {
    logic              detected;
    logic              correctable;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [Z_BITS-1:0] mag;
  } result_t;

endpackage

// File: rtl/wxyz_check_nxn_if.sv
// wxyz_check_nxn_if: tile checksum input strobe and per-tile result record.
//   master: drives acc_valid, *_acc, *_ref; observes ready/dropped/done/err_*
//   slave : the checker itself
interface wxyz_check_nxn_if
  import abft_pkg::*;
#(
  parameter int addressWidth = ADDR_W,
  parameter int zBits        = Z_BITS
);
  logic                    acc_valid;
  logic [zBits-1:0]        w_acc;
  logic [zBits-1:0]        x_acc;
  logic [zBits-1:0]        y_acc;
  logic [zBits-1:0]        z_acc;
  logic [zBits-1:0]        w_ref;
  logic [zBits-1:0]        x_ref;
  logic [zBits-1:0]        y_ref;
  logic [zBits-1:0]        z_ref;
  logic                    ready;
  logic                    dropped;
  logic                    done;
  logic                    err_detected;
  logic                    err_correctable;
  logic [addressWidth-1:0] err_row;
  logic [addressWidth-1:0] err_col;
  logic [zBits-1:0]        err_mag;

  modport master (
    output acc_valid, w_acc, x_acc, y_acc, z_acc, w_ref, x_ref, y_ref, z_ref,
    input  ready, dropped, done, err_detected, err_correctable,
           err_row, err_col, err_mag
  );

  modport slave (
    input  acc_valid, w_acc, x_acc, y_acc, z_acc, w_ref, x_ref, y_ref, z_ref,
    output ready, dropped, done, err_detected, err_correctable,
           err_row, err_col, err_mag
  );
endinterface

// File: rtl/dff.sv
// dff: W-bit register with synchronous active-high reset to zero.
//   clk, rst : clock, synchronous reset
//   d / q    : next value / registered value
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end
endmodule

// File: rtl/wxyz_match_search.sv
// wxyz_match_search: running-sum comparator. While en_i is high the sum
// steps by step_i each cycle (sum = step*k); the first k whose sum equals
// target_i is latched.
//   clear_i        : zero the sum and forget any hit (wins over en_i)
//   en_i, k_i      : advance this cycle, current index
//   step_i         : increment per cycle
//   target_i       : value to match
//   sum_o          : current running sum (step*k)
//   hit_o, idx_o   : hit/index including this cycle's compare
module wxyz_match_search #(
  parameter int addressWidth = 2,
  parameter int zBits        = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    en_i,
  input  logic [zBits-1:0]        step_i,
  input  logic [zBits-1:0]        target_i,
  input  logic [addressWidth-1:0] k_i,
  output logic [zBits-1:0]        sum_o,
  output logic                    hit_o,
  output logic [addressWidth-1:0] idx_o
);
  logic [zBits-1:0]        sum_q, sum_d;
  logic                    found_q, found_d;
  logic [addressWidth-1:0] idx_q, idx_d;
  logic                    match;

  assign match = en_i && !found_q && (sum_q == target_i);
  assign hit_o = found_q | match;
  assign idx_o = match ? k_i : idx_q;
  assign sum_o = sum_q;

  always_comb begin
    sum_d   = sum_q;
    found_d = hit_o;
    idx_d   = idx_o;
    if (clear_i) begin
      sum_d   = '0;
      found_d = 1'b0;
      idx_d   = '0;
    end else if (en_i) begin
      sum_d = sum_q + step_i;
    end
  end

  dff #(.W(zBits))        u_sum   (.clk(clk), .rst(rst), .d(sum_d),   .q(sum_q));
  dff #(.W(1))            u_found (.clk(clk), .rst(rst), .d(found_d), .q(found_q));
  dff #(.W(addressWidth)) u_idx   (.clk(clk), .rst(rst), .d(idx_d),   .q(idx_q));
endmodule

// File: rtl/wxyz_check_nxn.sv
// wxyz_check_nxn: ABFT tile checker. Forms syndromes s = acc - ref for the
// w/x/y/z checksums of one NxN tile, detects a fault, locates a single bad
// element by sequential search (no multipliers) and reports one record.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of wxyz_check_nxn_if (strobe in, result out)
// Result widths follow abft_pkg::result_t, so addressWidth/zBits must match
// the package values.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready; syndromes captured on acc_valid
// CLASSIFY | clean tile, s_w==0 fault, or start the search
// SEARCH   | k=0..N-1, find first k with s_w*k == s_x (row), == s_y (col)
// ZCHK     | k=0..N-1, at k==col check s_x*k == s_z
// REPORT   | done pulse, result record valid
module wxyz_check_nxn
  import abft_pkg::*;
#(
  parameter int arraySize    = ARRAY_SIZE,
  parameter int addressWidth = ADDR_W,
  parameter int zBits        = Z_BITS
) (
  input  logic             clk,
  input  logic             rst,
  wxyz_check_nxn_if.slave  bus
);
  localparam logic [addressWidth-1:0] K_LAST = addressWidth'(arraySize - 1);

  logic [2:0]              state_q, state_d;
  logic [addressWidth-1:0] k_q, k_d;
  logic [zBits-1:0]        s_w_q, s_w_d, s_x_q, s_x_d, s_y_q, s_y_d, s_z_q, s_z_d;
  logic [addressWidth-1:0] row_q, row_d, col_q, col_d;
  logic                    z_bad_q, z_bad_d;
  logic                    done_q, done_d;
  logic                    dropped_q, dropped_d;
  result_t                 res_q, res_d;

  logic                    clr_srch;
  logic                    row_en, col_en;
  logic [zBits-1:0]        row_step;
  logic [zBits-1:0]        row_sum, col_sum;
  logic                    row_hit, col_hit;
  logic [addressWidth-1:0] row_idx, col_idx;
  logic                    k_last;

  assign k_last = (k_q == K_LAST);
  assign row_en = (state_q == ST_SEARCH) || (state_q == ST_ZCHK);
  assign col_en = (state_q == ST_SEARCH);
  // The row instance becomes the s_x*k generator during ZCHK.
  assign row_step = (state_q == ST_ZCHK) ? s_x_q : s_w_q;

  wxyz_match_search #(.addressWidth(addressWidth), .zBits(zBits)) u_row (
    .clk(clk), .rst(rst), .clear_i(clr_srch), .en_i(row_en),
    .step_i(row_step), .target_i(s_x_q), .k_i(k_q),
    .sum_o(row_sum), .hit_o(row_hit), .idx_o(row_idx)
  );

  wxyz_match_search #(.addressWidth(addressWidth), .zBits(zBits)) u_col (
    .clk(clk), .rst(rst), .clear_i(clr_srch), .en_i(col_en),
    .step_i(s_w_q), .target_i(s_y_q), .k_i(k_q),
    .sum_o(col_sum), .hit_o(col_hit), .idx_o(col_idx)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    s_w_d     = s_w_q;
    s_x_d     = s_x_q;
    s_y_d     = s_y_q;
    s_z_d     = s_z_q;
    row_d     = row_q;
    col_d     = col_q;
    z_bad_d   = z_bad_q;
    res_d     = res_q;
    done_d    = 1'b0;
    clr_srch  = 1'b0;
    dropped_d = bus.acc_valid && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (bus.acc_valid) begin
          s_w_d   = bus.w_acc - bus.w_ref;
          s_x_d   = bus.x_acc - bus.x_ref;
          s_y_d   = bus.y_acc - bus.y_ref;
          s_z_d   = bus.z_acc - bus.z_ref;
          state_d = ST_CLASSIFY;
        end
      end

      ST_CLASSIFY: begin
        k_d      = '0;
        z_bad_d  = 1'b0;
        clr_srch = 1'b1;
        if (s_w_q == '0) begin
          // Covers both the clean tile and the unlocatable s_w==0 fault.
          res_d.detected    = (s_x_q != '0) || (s_y_q != '0) || (s_z_q != '0);
          res_d.correctable = 1'b0;
          res_d.row         = '0;
          res_d.col         = '0;
          res_d.mag         = s_w_q;
          done_d            = 1'b1;
          state_d           = ST_REPORT;
        end else begin
          state_d = ST_SEARCH;
        end
      end

      ST_SEARCH: begin
        k_d = k_last ? '0 : k_q + addressWidth'(1);
        if (k_last) begin
          row_d = row_idx;
          col_d = col_idx;
          if (row_hit && col_hit) begin
            clr_srch = 1'b1;
            state_d  = ST_ZCHK;
          end else begin
            res_d.detected    = 1'b1;
            res_d.correctable = 1'b0;
            res_d.row         = '0;
            res_d.col         = '0;
            res_d.mag         = s_w_q;
            done_d            = 1'b1;
            state_d           = ST_REPORT;
          end
        end
      end

      ST_ZCHK: begin
        k_d = k_last ? '0 : k_q + addressWidth'(1);
        if ((k_q == col_q) && (row_sum != s_z_q)) z_bad_d = 1'b1;
        if (k_last) begin
          res_d.detected    = 1'b1;
          res_d.correctable = !z_bad_d;
          res_d.row         = z_bad_d ? '0 : row_q;
          res_d.col         = z_bad_d ? '0 : col_q;
          res_d.mag         = s_w_q;
          done_d            = 1'b1;
          state_d           = ST_REPORT;
        end
      end

      ST_REPORT: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  dff #(.W(3))               u_state   (.clk(clk), .rst(rst), .d(state_d),   .q(state_q));
  dff #(.W(addressWidth))    u_k       (.clk(clk), .rst(rst), .d(k_d),       .q(k_q));
  dff #(.W(zBits))           u_s_w     (.clk(clk), .rst(rst), .d(s_w_d),     .q(s_w_q));
  dff #(.W(zBits))           u_s_x     (.clk(clk), .rst(rst), .d(s_x_d),     .q(s_x_q));
  dff #(.W(zBits))           u_s_y     (.clk(clk), .rst(rst), .d(s_y_d),     .q(s_y_q));
  dff #(.W(zBits))           u_s_z     (.clk(clk), .rst(rst), .d(s_z_d),     .q(s_z_q));
  dff #(.W(addressWidth))    u_row_q   (.clk(clk), .rst(rst), .d(row_d),     .q(row_q));
  dff #(.W(addressWidth))    u_col_q   (.clk(clk), .rst(rst), .d(col_d),     .q(col_q));
  dff #(.W(1))               u_z_bad   (.clk(clk), .rst(rst), .d(z_bad_d),   .q(z_bad_q));
  dff #(.W(1))               u_done    (.clk(clk), .rst(rst), .d(done_d),    .q(done_q));
  dff #(.W(1))               u_dropped (.clk(clk), .rst(rst), .d(dropped_d), .q(dropped_q));
  dff #(.W($bits(result_t))) u_res     (.clk(clk), .rst(rst), .d(res_d),     .q(res_q));

  assign bus.ready           = (state_q == ST_IDLE);
  assign bus.dropped         = dropped_q;
  assign bus.done            = done_q;
  assign bus.err_detected    = res_q.detected;
  assign bus.err_correctable = res_q.correctable;
  assign bus.err_row         = res_q.row;
  assign bus.err_col         = res_q.col;
  assign bus.err_mag         = res_q.mag;
endmodule

// File: tb/tb_wxyz_check_nxn.sv
// tb_wxyz_check_nxn: randomized and directed checks of wxyz_check_nxn
// against a behavioural model written directly from the checksum rules.
module tb_wxyz_check_nxn;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int ZB = 28;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  wxyz_check_nxn_if bus ();
  wxyz_check_nxn dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural model: linear search over k with plain multiplication.
  function automatic void model(input logic [ZB-1:0] sw, sx, sy, sz,
                                output int lat, output logic det, output logic cor,
                                output logic [AW-1:0] row, output logic [AW-1:0] col);
    int ri, ci;
    logic [ZB-1:0] p;
    det = (sw != 0) || (sx != 0) || (sy != 0) || (sz != 0);
    cor = 1'b0; row = '0; col = '0; ri = -1; ci = -1;
    if (!det || sw == 0) begin lat = 2; return; end
    for (int k = 0; k < N; k++) begin
      p = sw * ZB'(k);
      if (ri < 0 && p == sx) ri = k;
      if (ci < 0 && p == sy) ci = k;
    end
    if (ri < 0 || ci < 0) begin lat = 2 + N; return; end
    lat = 2 + 2 * N;
    p = sx * ZB'(ci);
    cor = (p == sz);
    if (cor) begin row = AW'(ri); col = AW'(ci); end
  endfunction

  task automatic load_tile(input logic [ZB-1:0] sw, sx, sy, sz);
    logic [ZB-1:0] r;
    r = ZB'($urandom); bus.w_ref = r; bus.w_acc = r + sw;
    r = ZB'($urandom); bus.x_ref = r; bus.x_acc = r + sx;
    r = ZB'($urandom); bus.y_ref = r; bus.y_acc = r + sy;
    r = ZB'($urandom); bus.z_ref = r; bus.z_acc = r + sz;
  endtask

  // Drives one tile from IDLE and measures latency (cycles after the strobe).
  task automatic drive_tile(input logic [ZB-1:0] sw, sx, sy, sz,
                            output int lat, output logic det, output logic cor,
                            output logic [AW-1:0] row, output logic [AW-1:0] col,
                            output logic [ZB-1:0] mag, output logic rdy1,
                            output logic rdy_after);
    det = 1'bx; cor = 1'bx; row = 'x; col = 'x; mag = 'x; rdy1 = 1'bx; lat = -1;
    @(negedge clk);
    load_tile(sw, sx, sy, sz);
    bus.acc_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.acc_valid = 1'b0;
      if (c == 1) rdy1 = bus.ready;
      if (bus.done === 1'b1) begin
        lat = c; det = bus.err_detected; cor = bus.err_correctable;
        row = bus.err_row; col = bus.err_col; mag = bus.err_mag;
        break;
      end
    end
    @(negedge clk);
    rdy_after = (bus.ready === 1'b1) && (bus.done === 1'b0);
  endtask

  task automatic test_reset();
    bus.acc_valid = 1'b0;
    load_tile('0, '0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.ready, bus.done, bus.dropped, bus.err_detected, bus.err_correctable} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_flags: got rdy/done/drop/det/cor=%b want 10000",
               {bus.ready, bus.done, bus.dropped, bus.err_detected, bus.err_correctable});
    end
    total++;
    if ({bus.err_row, bus.err_col, bus.err_mag} !== '0) begin
      bad++;
      $display("FAIL reset_fields: got row=%0d col=%0d mag=%0h want 0", bus.err_row, bus.err_col, bus.err_mag);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [ZB-1:0] dv [6][4];
    int            dlat [6];
    int lat, mlat;
    logic det, cor, mdet, mcor, r1, ra;
    logic [AW-1:0] row, col, mrow, mcol;
    logic [ZB-1:0] mag;
    dv[0] = '{ZB'(0), ZB'(0),  ZB'(0),  ZB'(0)};  dlat[0] = 2;
    dv[1] = '{ZB'(5), ZB'(10), ZB'(15), ZB'(30)}; dlat[1] = 10;
    dv[2] = '{ZB'(-3), ZB'(0), ZB'(0),  ZB'(0)};  dlat[2] = 10;
    dv[3] = '{ZB'(0), ZB'(4),  ZB'(0),  ZB'(0)};  dlat[3] = 2;
    dv[4] = '{ZB'(5), ZB'(7),  ZB'(0),  ZB'(0)};  dlat[4] = 6;
    dv[5] = '{ZB'(5), ZB'(10), ZB'(15), ZB'(31)}; dlat[5] = 10;
    for (int i = 0; i < 6; i++) begin
      model(dv[i][0], dv[i][1], dv[i][2], dv[i][3], mlat, mdet, mcor, mrow, mcol);
      drive_tile(dv[i][0], dv[i][1], dv[i][2], dv[i][3], lat, det, cor, row, col, mag, r1, ra);
      total++;
      if (lat != dlat[i]) begin
        bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, dlat[i]);
      end
      total++;
      if ({det, cor, row, col} !== {mdet, mcor, mrow, mcol}) begin
        bad++;
        $display("FAIL dir%0d_result: got det=%b cor=%b row=%0d col=%0d want det=%b cor=%b row=%0d col=%0d",
                 i, det, cor, row, col, mdet, mcor, mrow, mcol);
      end
      total++;
      if (mag !== dv[i][0]) begin
        bad++; $display("FAIL dir%0d_mag: got %0h want %0h", i, mag, dv[i][0]);
      end
      total++;
      if ({r1, ra} !== 2'b01) begin
        bad++; $display("FAIL dir%0d_ready: got busy=%b after=%b want 0 1", i, r1, ra);
      end
    end
  endtask

  task automatic test_random();
    int lat, mlat, ii, jj, which;
    logic det, cor, mdet, mcor, r1, ra;
    logic [AW-1:0] row, col, mrow, mcol;
    logic [ZB-1:0] mag, e, sw, sx, sy, sz, flip;
    for (int n = 0; n < 30; n++) begin
      e  = ZB'($urandom);
      ii = $urandom_range(0, N - 1);
      jj = $urandom_range(0, N - 1);
      sw = e; sx = e * ZB'(ii); sy = e * ZB'(jj); sz = sx * ZB'(jj);
      if ($urandom_range(0, 2) == 0) begin
        which = $urandom_range(0, 3);
        flip  = ZB'(1) << $urandom_range(0, ZB - 1);
        case (which)
          0: sw = sw ^ flip;
          1: sx = sx ^ flip;
          2: sy = sy ^ flip;
          default: sz = sz ^ flip;
        endcase
      end
      if ($urandom_range(0, 9) == 0) begin sw = '0; sx = '0; sy = '0; sz = '0; end
      model(sw, sx, sy, sz, mlat, mdet, mcor, mrow, mcol);
      drive_tile(sw, sx, sy, sz, lat, det, cor, row, col, mag, r1, ra);
      total++;
      if (lat != mlat) begin
        bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, mlat);
      end
      total++;
      if ({det, cor, row, col, mag} !== {mdet, mcor, mrow, mcol, sw}) begin
        bad++;
        $display("FAIL rnd%0d_result: got det=%b cor=%b row=%0d col=%0d mag=%0h want det=%b cor=%b row=%0d col=%0d mag=%0h",
                 n, det, cor, row, col, mag, mdet, mcor, mrow, mcol, sw);
      end
      total++;
      if ({r1, ra} !== 2'b01) begin
        bad++; $display("FAIL rnd%0d_ready: got busy=%b after=%b want 0 1", n, r1, ra);
      end
    end
  endtask

  task automatic test_drop_search();
    int lat;
    @(negedge clk);
    load_tile(ZB'(5), ZB'(10), ZB'(15), ZB'(30));
    bus.acc_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.acc_valid = (c == 4);
      if (c == 4) load_tile(ZB'(1), ZB'(2), ZB'(3), ZB'(9));
      if (c == 4 || c == 6) begin
        total++;
        if (bus.dropped !== 1'b0) begin
          bad++; $display("FAIL drop_search_quiet_c%0d: got %b want 0", c, bus.dropped);
        end
      end
      if (c == 5) begin
        total++;
        if (bus.dropped !== 1'b1) begin
          bad++; $display("FAIL drop_search_pulse: got %b want 1", bus.dropped);
        end
      end
      if (bus.done === 1'b1) begin lat = c; break; end
    end
    total++;
    if (lat != 10) begin
      bad++; $display("FAIL drop_search_latency: got %0d want 10", lat);
    end
    total++;
    if ({bus.err_detected, bus.err_correctable, bus.err_row, bus.err_col, bus.err_mag} !==
        {1'b1, 1'b1, AW'(2), AW'(3), ZB'(5)}) begin
      bad++;
      $display("FAIL drop_search_result: got det=%b cor=%b row=%0d col=%0d mag=%0h want 1 1 2 3 5",
               bus.err_detected, bus.err_correctable, bus.err_row, bus.err_col, bus.err_mag);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_report_hold();
    int lat;
    logic stayed;
    @(negedge clk);
    load_tile(ZB'(5), ZB'(7), ZB'(0), ZB'(0));
    bus.acc_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.acc_valid = 1'b0;
      if (bus.done === 1'b1) begin lat = c; break; end
    end
    total++;
    if (lat != 6) begin
      bad++; $display("FAIL drop_report_latency: got %0d want 6", lat);
    end
    bus.acc_valid = 1'b1;
    @(negedge clk);
    bus.acc_valid = 1'b0;
    total++;
    if ({bus.dropped, bus.ready, bus.done} !== 3'b110) begin
      bad++; $display("FAIL drop_report_pulse: got drop/rdy/done=%b want 110", {bus.dropped, bus.ready, bus.done});
    end
    stayed = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.ready !== 1'b1 || bus.done !== 1'b0) stayed = 1'b0;
    end
    total++;
    if (stayed !== 1'b1) begin
      bad++; $display("FAIL drop_report_idle: got stayed=%b want 1", stayed);
    end
    total++;
    if ({bus.err_detected, bus.err_correctable, bus.err_row, bus.err_col, bus.err_mag} !==
        {1'b1, 1'b0, AW'(0), AW'(0), ZB'(5)}) begin
      bad++;
      $display("FAIL result_hold: got det=%b cor=%b row=%0d col=%0d mag=%0h want 1 0 0 0 5",
               bus.err_detected, bus.err_correctable, bus.err_row, bus.err_col, bus.err_mag);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    load_tile(ZB'(5), ZB'(10), ZB'(15), ZB'(30));
    bus.acc_valid = 1'b1;
    @(posedge clk);
    dones = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      bus.acc_valid = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 4) begin
        total++;
        if ({bus.ready, bus.err_detected, bus.err_mag} !== {1'b1, 1'b0, ZB'(0)}) begin
          bad++;
          $display("FAIL reset_mid_idle: got rdy=%b det=%b mag=%0h want 1 0 0", bus.ready, bus.err_detected, bus.err_mag);
        end
        rst = 1'b0;
      end
      if (bus.done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL reset_mid_nodone: got %0d done pulses want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic det, cor, r1, ra;
    logic [AW-1:0] row, col;
    logic [ZB-1:0] mag;
    for (int n = 0; n < 2; n++) begin
      drive_tile(ZB'(7 + n), ZB'(7 + n), ZB'(2 * (7 + n)), ZB'(2 * (7 + n)),
                 lat, det, cor, row, col, mag, r1, ra);
      total++;
      if ({lat == 10, det, cor, row, col, mag} !== {1'b1, 1'b1, 1'b1, AW'(1), AW'(2), ZB'(7 + n)}) begin
        bad++;
        $display("FAIL b2b%0d: got lat=%0d det=%b cor=%b row=%0d col=%0d mag=%0h want 10 1 1 1 2 %0h",
                 n, lat, det, cor, row, col, mag, 7 + n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_drop_search();
    test_drop_report_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wxyz_check_nxn.md
Name: wxyz_check_nxn

Overview:
- Sits directly downstream of the wxyz accumulator in the ABFT datapath.
- Takes the four accumulated output checksums (w, x, y, z) of one NxN tile and the four predicted reference checksums. Forms the syndromes.
- Detects a fault, then locates and sizes a single erroneous element by sequential search, with no multipliers or dividers.
- Reports one result record per tile to the fault-handling logic.

Parameters:
- arraySize, 4, tile dimension N (rows = columns).
- addressWidth, 2, width of row/column index; equals clog2(arraySize).
- zBits, 28, checksum and syndrome width (two's complement).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- acc_valid  in  1  one-cycle strobe; w/x/y/z_acc and w/x/y/z_ref are valid this cycle
- w_acc, x_acc, y_acc, z_acc  in  zBits each  accumulated checksums from the array
- w_ref, x_ref, y_ref, z_ref  in  zBits each  predicted checksums
- ready  out  1  high only in IDLE; a strobe is accepted only when ready=1
- dropped  out  1  one-cycle pulse when acc_valid arrives while ready=0
- done  out  1  one-cycle pulse; result fields valid
- err_detected  out  1  any syndrome nonzero
- err_correctable  out  1  single-element error located and consistent
- err_row  out  addressWidth  located row
- err_col  out  addressWidth  located column
- err_mag  out  zBits  error magnitude (s_w)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Checksum definitions, for element error e at (i,j):
  - s_w = e
  - s_x = e*i
  - s_y = e*j
  - s_z = e*i*j
  - Each syndrome is s = acc - ref, computed modulo 2^zBits.
- Reset values: state IDLE, ready=1, and dropped, done, err_detected, err_correctable, err_row, err_col, err_mag all 0.
- Result fields hold their values until the next done.
- FSM states: IDLE, CLASSIFY, SEARCH, ZCHK, REPORT.
- IDLE: on acc_valid, register the four syndromes and go to CLASSIFY.
- CLASSIFY (1 cycle):
  - All syndromes zero: go to REPORT with detected=0.
  - s_w==0 with any other syndrome nonzero: go to REPORT with detected=1, correctable=0.
  - Otherwise: clear k and both running sums, go to SEARCH.
- SEARCH (exactly arraySize cycles, k=0..N-1):
  - Running sum r = s_w*k (starts at 0, adds s_w each cycle).
  - The first k with r==s_x latches row_found and row.
  - The first k with r==s_y latches col_found and col.
  - After k==N-1: go to ZCHK if both are found, else go to REPORT uncorrectable.
- ZCHK (exactly arraySize cycles):
  - Running sum q = s_x*k.
  - At k==col, compare q with s_z; on mismatch the result is uncorrectable.
  - After k==N-1, go to REPORT.
- REPORT (1 cycle):
  - Assert done and drive the result fields.
  - err_mag = s_w; err_row/err_col are driven only if correctable, else 0.
  - Go to IDLE.
- Latency from the acc_valid cycle t:
  - Clean tile: done at t+2.
  - s_w==0 fault: done at t+2.
  - Located or unlocated after search: done at t+2+N.
  - Full path: done at t+2+2N (t+10 for N=4).
- Row or column 0: s_x or s_y equals 0 matches at k=0; this is legal.
- acc_valid in any non-IDLE state, including REPORT: ignored, and dropped pulses the next cycle. Internal state is unaffected.
- rst asserted mid-search: returns to IDLE next edge. Any pending result is discarded and done is not asserted.
- Arithmetic wraps at zBits and is never saturated. Comparisons are bitwise equality.

Decomposition:
- Shared package abft_pkg holds:
  - the state enum (IDLE, CLASSIFY, SEARCH, ZCHK, REPORT);
  - a result struct {detected, correctable, row, col, mag}.
- Registers use the existing dff module.
- One sub-module is natural: wxyz_match_search, the reusable running-sum comparator (step, target, k → first-hit flag and index). It is instantiated twice in SEARCH (row, col); ZCHK reuses one instance with step s_x.

Test Plan:
- acc==ref on all four, acc_valid at t: done at t+2, detected=0, correctable=0, ready back to 1 at t+3.
- Error e=5 at (2,3), N=4: syndromes s_w=5, s_x=10, s_y=15, s_z=30. Expect done at t+10, detected=1, correctable=1, row=2, col=3, mag=5.
- Error e=-3 (two's complement) at (0,0): all syndromes except s_w are 0. Expect row=0, col=0, mag=-3, correctable=1.
- s_w=0 with s_x=4: done at t+2, detected=1, correctable=0. Also s_w=5, s_x=7 (no k matches): done at t+6, correctable=0.
- Syndromes of the (2,3) case but s_z=31: done at t+10, detected=1, correctable=0, row=0, col=0.
- acc_valid repeated at t+4 during SEARCH: dropped=1 at t+5 and first result unchanged. Separately, rst at t+3: ready=1 at t+4 and no done.
